conv_layer_sched: RTL and testbench

- Layer-level scheduler for the CONV engine; sits between the system memory interface and one CONV instance.
- Sequences one engine pass per (output channel, input channel) pair: co outer, ci inner.
- Generates IFM and weight read addresses from the engine's ifm_read/wgt_read strobes.
- Generates OFM write addresses/enables from out_valid on the last ci pass, and reports layer done.

---
 rtl/conv_pkg.sv | 50 +++++
 rtl/conv_layer_sched_if.sv | 54 +++++
 rtl/sat_counter.sv | 62 ++++++
 rtl/conv_layer_sched.sv | 211 +++++++++++++++++++++
 tb/tb_conv_layer_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the CONV layer scheduler.
//   - state_e          : scheduler FSM states
//   - DEF_*            : default layer geometry
//   - ofm_size/area    : derived geometry helpers (OFM side, square areas)
//   - cnt_width        : bits needed to hold 0..max_val
//   - idx_width        : width of a channel index for n channels
//   - addr_fits        : true when an address range fits in w address bits
// -----------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam int DEF_IFM_SIZE    = 27;
  localparam int DEF_KERNEL_SIZE = 5;
  localparam int DEF_STRIDE      = 1;
  localparam int DEF_PAD         = 2;
  localparam int DEF_CI          = 3;
  localparam int DEF_CO          = 8;
  localparam int DEF_ADDR_WIDTH  = 16;

  function automatic int ofm_size(input int ifm, input int k, input int s, input int p);
    return (ifm - k + 2 * p) / s + 1;
  endfunction

  function automatic int area(input int side);
    return side * side;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int idx_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // A range of v words occupies addresses 0..v-1, so v may equal 2^w.
  function automatic bit addr_fits(input longint v, input int w);
    return v <= (longint'(1) << w);
  endfunction

endpackage

// File: rtl/conv_layer_sched_if.sv
// -----------------------------------------------------------------------------
// conv_layer_sched_if
// Engine handshake and memory address bus between the layer scheduler and one
// CONV engine instance.
//   start_conv : scheduler -> engine, 1-cycle pass start
//   end_conv   : engine -> scheduler, 1-cycle pass complete
//   ifm_read   : engine consumes one IFM word this cycle
//   wgt_read   : engine consumes one weight word this cycle
//   out_valid  : engine produces one output word this cycle
//   ifm_addr   : IFM read address
//   wgt_addr   : weight read address
//   ofm_addr   : OFM write address
//   ofm_we     : OFM write enable
// Modports: master = scheduler side, slave = engine/memory side.
// -----------------------------------------------------------------------------
interface conv_layer_sched_if #(
  parameter int ADDR_WIDTH = 16
);

  logic                  start_conv;
  logic                  end_conv;
  logic                  ifm_read;
  logic                  wgt_read;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] ifm_addr;
  logic [ADDR_WIDTH-1:0] wgt_addr;
  logic [ADDR_WIDTH-1:0] ofm_addr;
  logic                  ofm_we;

  modport master (
    output start_conv,
    output ifm_addr,
    output wgt_addr,
    output ofm_addr,
    output ofm_we,
    input  end_conv,
    input  ifm_read,
    input  wgt_read,
    input  out_valid
  );

  modport slave (
    input  start_conv,
    input  ifm_addr,
    input  wgt_addr,
    input  ofm_addr,
    input  ofm_we,
    output end_conv,
    output ifm_read,
    output wgt_read,
    output out_valid
  );

endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for per-pass word counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event
//   clr        : synchronous clear (wins over inc)
//   count      : current count, 0..MAX
//   ovf        : combinational, high when inc arrives after MAX+1 events
// The counter accepts MAX+1 events (addresses 0..MAX); the event that reaches
// the last address only marks the counter full. Only an event beyond that is
// an overrun, and the count holds at MAX throughout.
// -----------------------------------------------------------------------------
module sat_counter
  import conv_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic             full_q, full_d;

  always_comb begin
    count_d = count_q;
    full_d  = full_q;
    ovf     = 1'b0;
    if (clr) begin
      count_d = '0;
      full_d  = 1'b0;
    end else if (inc) begin
      if (full_q) begin
        ovf = 1'b1;
      end else if (count_q == MAX_V) begin
        full_d = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/conv_layer_sched.sv
// -----------------------------------------------------------------------------
// conv_layer_sched
// Layer-level scheduler for one CONV engine. Runs one engine pass per
// (output channel, input channel) pair, co outer / ci inner, and turns the
// engine's read/write strobes into IFM, weight and OFM addresses.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : 1-cycle layer start request (ignored while not idle)
//   abort      : synchronous abort back to idle, highest priority
//   busy       : layer in progress
//   done       : 1-cycle pulse when the last pass has completed
//   err        : sticky address-overrun flag, cleared by the next start
//   ci_idx     : current input channel
//   co_idx     : current output channel
//   bus        : engine handshake + memory addresses (master side)
// -----------------------------------------------------------------------------
module conv_layer_sched
  import conv_pkg::*;
#(
  parameter int IFM_SIZE    = DEF_IFM_SIZE,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int STRIDE      = DEF_STRIDE,
  parameter int PAD         = DEF_PAD,
  parameter int CI          = DEF_CI,
  parameter int CO          = DEF_CO,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [idx_width(CI)-1:0] ci_idx,
  output logic [idx_width(CO)-1:0] co_idx,
  conv_layer_sched_if.master       bus
);

  localparam int OFM_SIZE = ofm_size(IFM_SIZE, KERNEL_SIZE, STRIDE, PAD);
  localparam int IFM_AREA = area(IFM_SIZE);
  localparam int KER_AREA = area(KERNEL_SIZE);
  localparam int OFM_AREA = area(OFM_SIZE);

  localparam int CI_W  = idx_width(CI);
  localparam int CO_W  = idx_width(CO);
  localparam int PIX_W = cnt_width(IFM_AREA - 1);
  localparam int K_W   = cnt_width(KER_AREA - 1);
  localparam int O_W   = cnt_width(OFM_AREA - 1);

  // Address-space range checks: refuse to elaborate a layer whose tensors do
  // not fit in the address width.
  if (!addr_fits(longint'(CO) * longint'(OFM_AREA), ADDR_WIDTH)) begin : g_ofm_range_err
    $error("conv_layer_sched: CO*OFM_SIZE^2 exceeds the address space");
  end
  if (!addr_fits(longint'(CI) * longint'(IFM_AREA), ADDR_WIDTH)) begin : g_ifm_range_err
    $error("conv_layer_sched: CI*IFM_SIZE^2 exceeds the address space");
  end
  if (!addr_fits(longint'(CO) * longint'(CI) * longint'(KER_AREA), ADDR_WIDTH)) begin : g_wgt_range_err
    $error("conv_layer_sched: CO*CI*KERNEL_SIZE^2 exceeds the address space");
  end

  localparam logic [ADDR_WIDTH-1:0] IFM_AREA_A = ADDR_WIDTH'(IFM_AREA);
  localparam logic [ADDR_WIDTH-1:0] KER_AREA_A = ADDR_WIDTH'(KER_AREA);
  localparam logic [ADDR_WIDTH-1:0] OFM_AREA_A = ADDR_WIDTH'(OFM_AREA);
  localparam logic [ADDR_WIDTH-1:0] CI_A       = ADDR_WIDTH'(CI);
  localparam logic [CI_W-1:0]       CI_LAST    = CI_W'(CI - 1);
  localparam logic [CO_W-1:0]       CO_LAST    = CO_W'(CO - 1);

  state_e          state_q, state_d;
  logic [CI_W-1:0] ci_q, ci_d;
  logic [CO_W-1:0] co_q, co_d;
  logic            err_q, err_d;

  logic             run;
  logic             start_acc;
  logic             cnt_clr;
  logic             last_ci;
  logic             last_co;
  logic             ofm_we;
  logic [PIX_W-1:0] pix_cnt;
  logic [K_W-1:0]   k_cnt;
  logic [O_W-1:0]   o_cnt;
  logic             pix_ovf;
  logic             k_ovf;
  logic             o_ovf;

  assign run       = (state_q == ST_RUN);
  assign start_acc = (state_q == ST_IDLE) && start && !abort;
  assign last_ci   = (ci_q == CI_LAST);
  assign last_co   = (co_q == CO_LAST);

  // Counters restart for every pass (LAUNCH), for a new layer, and on abort.
  assign cnt_clr = abort || start_acc || (state_q == ST_LAUNCH);

  // Only the final input-channel pass carries finished output words.
  assign ofm_we = bus.out_valid && last_ci && run;

  // Strobes outside RUN never reach the counters, so they cannot set err.
  sat_counter #(.WIDTH(PIX_W), .MAX(IFM_AREA - 1)) u_pix_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.ifm_read && run),
    .clr   (cnt_clr),
    .count (pix_cnt),
    .ovf   (pix_ovf)
  );

  sat_counter #(.WIDTH(K_W), .MAX(KER_AREA - 1)) u_k_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.wgt_read && run),
    .clr   (cnt_clr),
    .count (k_cnt),
    .ovf   (k_ovf)
  );

  sat_counter #(.WIDTH(O_W), .MAX(OFM_AREA - 1)) u_o_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ofm_we),
    .clr   (cnt_clr),
    .count (o_cnt),
    .ovf   (o_ovf)
  );

  // Pass sequencing. The channel indices advance on end_conv; a write that
  // lands in the same cycle still uses the old indices because the address
  // is formed from the registered values.
  always_comb begin
    state_d = state_q;
    ci_d    = ci_q;
    co_d    = co_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LAUNCH;
          ci_d    = '0;
          co_d    = '0;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.end_conv) begin
          if (!last_ci) begin
            ci_d    = ci_q + CI_W'(1);
            state_d = ST_NEXT;
          end else if (!last_co) begin
            ci_d    = '0;
            co_d    = co_q + CO_W'(1);
            state_d = ST_NEXT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_NEXT: begin
        state_d = ST_LAUNCH;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      ci_d    = '0;
      co_d    = '0;
    end
  end

  // Overflow strobes are already suppressed by the counter clear on abort,
  // so err simply holds across an abort.
  always_comb begin
    err_d = err_q | pix_ovf | k_ovf | o_ovf;
    if (start_acc) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ci_q    <= '0;
      co_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ci_q    <= ci_d;
      co_q    <= co_d;
      err_q   <= err_d;
    end
  end

  assign busy           = (state_q == ST_LAUNCH) || (state_q == ST_RUN) || (state_q == ST_NEXT);
  assign done           = (state_q == ST_DONE);
  assign err            = err_q;
  assign ci_idx         = ci_q;
  assign co_idx         = co_q;
  assign bus.start_conv = (state_q == ST_LAUNCH);
  assign bus.ofm_we     = ofm_we;

  assign bus.ifm_addr = ADDR_WIDTH'(ci_q) * IFM_AREA_A + ADDR_WIDTH'(pix_cnt);
  assign bus.wgt_addr = (ADDR_WIDTH'(co_q) * CI_A + ADDR_WIDTH'(ci_q)) * KER_AREA_A
                        + ADDR_WIDTH'(k_cnt);
  assign bus.ofm_addr = ADDR_WIDTH'(co_q) * OFM_AREA_A + ADDR_WIDTH'(o_cnt);

endmodule

// File: tb/tb_conv_layer_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_conv_layer_sched
// Bench for the layer scheduler on a small layer: IFM 4x4, 3x3 kernel, pad 1,
// stride 1 (OFM 4x4), 2 input and 2 output channels.
// -----------------------------------------------------------------------------
module tb_conv_layer_sched;

  localparam int IFM_SIZE = 4;
  localparam int KS       = 3;
  localparam int STR      = 1;
  localparam int PAD      = 1;
  localparam int CI       = 2;
  localparam int CO       = 2;
  localparam int AW       = 16;
  localparam int OFM_SIZE = (IFM_SIZE - KS + 2 * PAD) / STR + 1;
  localparam int IFM_AREA = IFM_SIZE * IFM_SIZE;
  localparam int KER_AREA = KS * KS;
  localparam int OFM_AREA = OFM_SIZE * OFM_SIZE;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] ci_idx;
  logic [1:0] co_idx;

  conv_layer_sched_if #(.ADDR_WIDTH(AW)) bus ();

  conv_layer_sched #(
    .IFM_SIZE    (IFM_SIZE),
    .KERNEL_SIZE (KS),
    .STRIDE      (STR),
    .PAD         (PAD),
    .CI          (CI),
    .CO          (CO),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .ci_idx (ci_idx),
    .co_idx (co_idx),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Behavioural model: layer progress expressed as "which pass, how many words
  // has the engine moved in it". Word counts run 0..AREA; an address never
  // goes past AREA-1 and a word beyond AREA is an overrun.
  // ---------------------------------------------------------------------------
  bit m_busy = 0, m_done = 0, m_sc = 0, m_gap = 0, m_active = 0, m_err = 0;
  int m_ci = 0, m_co = 0, m_pix = 0, m_k = 0, m_o = 0;

  function automatic int clip(input int n, input int lim);
    return (n > lim - 1) ? lim - 1 : n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_sc <= 0; m_gap <= 0; m_active <= 0; m_err <= 0;
      m_ci <= 0; m_co <= 0; m_pix <= 0; m_k <= 0; m_o <= 0;
    end else if (abort) begin
      m_busy <= 0; m_done <= 0; m_sc <= 0; m_gap <= 0; m_active <= 0;
      m_ci <= 0; m_co <= 0; m_pix <= 0; m_k <= 0; m_o <= 0;
    end else begin
      m_done <= 0;
      m_sc   <= m_gap;
      m_gap  <= 0;
      if (!m_busy && !m_done && start) begin
        m_busy <= 1; m_sc <= 1; m_err <= 0;
        m_ci <= 0; m_co <= 0; m_pix <= 0; m_k <= 0; m_o <= 0;
      end
      if (m_sc) begin
        m_active <= 1; m_pix <= 0; m_k <= 0; m_o <= 0;
      end
      if (m_active) begin
        if (bus.ifm_read) begin
          if (m_pix == IFM_AREA) m_err <= 1; else m_pix <= m_pix + 1;
        end
        if (bus.wgt_read) begin
          if (m_k == KER_AREA) m_err <= 1; else m_k <= m_k + 1;
        end
        if (bus.out_valid && m_ci == CI - 1) begin
          if (m_o == OFM_AREA) m_err <= 1; else m_o <= m_o + 1;
        end
        if (bus.end_conv) begin
          m_active <= 0;
          if (m_ci == CI - 1 && m_co == CO - 1) begin
            m_done <= 1;
            m_busy <= 0;
          end else begin
            m_gap <= 1;
            if (m_ci == CI - 1) begin
              m_ci <= 0;
              m_co <= m_co + 1;
            end else begin
              m_ci <= m_ci + 1;
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle, DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("start_conv", bus.start_conv, m_sc);
      chk("ci_idx", ci_idx, m_ci);
      chk("co_idx", co_idx, m_co);
      chk("ifm_addr", bus.ifm_addr, m_ci * IFM_AREA + clip(m_pix, IFM_AREA));
      chk("wgt_addr", bus.wgt_addr, (m_co * CI + m_ci) * KER_AREA + clip(m_k, KER_AREA));
      chk("ofm_addr", bus.ofm_addr, m_co * OFM_AREA + clip(m_o, OFM_AREA));
      chk("ofm_we", bus.ofm_we, bus.out_valid && m_active && (m_ci == CI - 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Event monitor for the literal end-of-test expectations.
  // ---------------------------------------------------------------------------
  int          sc_cyc[$];
  int          ec_cyc[$];
  int          done_cyc[$];
  int          we_cnt, we_badci, we_last_addr, we_last_cyc;
  logic [31:0] we_seen;
  logic [31:0] ifm_seen;
  logic [35:0] wgt_seen;

  task automatic clear_mon();
    sc_cyc.delete(); ec_cyc.delete(); done_cyc.delete();
    we_cnt = 0; we_badci = 0; we_last_addr = -1; we_last_cyc = -1;
    we_seen = '0; ifm_seen = '0; wgt_seen = '0;
  endtask

  always @(negedge clk) begin
    if (bus.start_conv) sc_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
    if (bus.end_conv && busy) begin
      ec_cyc.push_back(cyc);
      $display("pass end: co=%0d ci=%0d cycle=%0d ifm=%0d wgt=%0d ofm=%0d err=%0d",
               co_idx, ci_idx, cyc, bus.ifm_addr, bus.wgt_addr, bus.ofm_addr, err);
    end
    if (bus.ofm_we) begin
      we_cnt++;
      if (ci_idx != 2'd1) we_badci++;
      if (bus.ofm_addr < 32) we_seen[bus.ofm_addr[4:0]] = 1'b1;
      we_last_addr = int'(bus.ofm_addr);
      we_last_cyc  = cyc;
    end
    if (busy && bus.ifm_read && bus.ifm_addr < 32) ifm_seen[bus.ifm_addr[4:0]] = 1'b1;
    if (busy && bus.wgt_read && bus.wgt_addr < 36) wgt_seen[bus.wgt_addr[5:0]] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. All drive at posedge+1.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_sc();
    int n;
    n = 0;
    while (!bus.start_conv && n < 30) begin
      step();
      n++;
    end
    if (!bus.start_conv) begin
      total++; bad++;
      $display("FAIL wait_start_conv: got no pulse within %0d cycles, required one", n);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 30) begin
      step();
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL wait_done: got no done within %0d cycles, required one", n);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  // One engine pass: strobes in consecutive RUN cycles, then end_conv (or
  // end_conv together with the final strobe cycle).
  task automatic engine_pass(input int nifm, input int nwgt, input int nout, input bit ov_on_end);
    int len;
    len = nifm;
    if (nwgt > len) len = nwgt;
    if (nout > len) len = nout;
    wait_sc();
    step();
    for (int i = 0; i < len; i++) begin
      bus.ifm_read  = (i < nifm);
      bus.wgt_read  = (i < nwgt);
      bus.out_valid = (i < nout);
      bus.end_conv  = ov_on_end && (i == len - 1);
      step();
    end
    bus.ifm_read = 1'b0; bus.wgt_read = 1'b0; bus.out_valid = 1'b0; bus.end_conv = 1'b0;
    if (!ov_on_end) begin
      bus.end_conv = 1'b1; step(); bus.end_conv = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  int t0;
  int n_done_before;

  initial begin
    bus.end_conv = 1'b0; bus.ifm_read = 1'b0; bus.wgt_read = 1'b0; bus.out_valid = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_start_conv", bus.start_conv, 0);
    chk("rst_ofm_we", bus.ofm_we, 0);
    rst_n = 1'b1;
    step();

    // ---------------- nominal layer + start-while-busy + last-pass corner ----
    clear_mon();
    t0 = cyc;
    pulse_start();
    fork
      begin
        engine_pass(16, 9, 16, 1'b0);
        engine_pass(16, 9, 16, 1'b0);
        engine_pass(16, 9, 16, 1'b0);
        engine_pass(16, 9, 16, 1'b1);
      end
      begin
        repeat (10) step();
        start = 1'b1; step(); start = 1'b0;
      end
    join
    wait_done();
    step();
    chk("nom_busy_after_done", busy, 0);
    chk("nom_n_start_conv", sc_cyc.size(), 4);
    chk("nom_start_latency", sc_cyc[0] - t0, 1);
    for (int i = 1; i < 4; i++) chk("nom_end_to_start", sc_cyc[i] - ec_cyc[i-1], 2);
    chk("nom_n_done", done_cyc.size(), 1);
    chk("nom_done_latency", done_cyc[0] - ec_cyc[3], 1);
    chk("nom_we_count", we_cnt, 32);
    chk("nom_we_bad_ci", we_badci, 0);
    chk("nom_we_all_addr", we_seen == 32'hFFFF_FFFF, 1);
    chk("nom_last_we_addr", we_last_addr, 31);
    chk("nom_last_we_cycle", we_last_cyc, ec_cyc[3]);
    chk("nom_ifm_all_addr", ifm_seen == 32'hFFFF_FFFF, 1);
    chk("nom_wgt_all_addr", wgt_seen == 36'hF_FFFF_FFFF, 1);
    chk("nom_err", err, 0);

    // ---------------- overrun ------------------------------------------------
    pulse_start();
    wait_sc();
    step();
    bus.ifm_read = 1'b1;
    repeat (17) step();
    bus.ifm_read = 1'b0;
    chk("ovr_ifm_addr_hold", bus.ifm_addr, 15);
    chk("ovr_err", err, 1);
    bus.end_conv = 1'b1; step(); bus.end_conv = 1'b0;
    engine_pass(16, 9, 16, 1'b0);
    engine_pass(16, 9, 16, 1'b0);
    engine_pass(16, 9, 16, 1'b0);
    wait_done();
    step();
    chk("ovr_err_after_done", err, 1);
    pulse_start();
    chk("ovr_err_cleared", err, 0);

    // ---------------- abort mid-pass (co=1, ci=0) ---------------------------
    engine_pass(16, 9, 16, 1'b0);
    engine_pass(16, 9, 16, 1'b0);
    wait_sc();
    step();
    chk("abt_co", co_idx, 1);
    chk("abt_ci", ci_idx, 0);
    bus.ifm_read = 1'b1; bus.wgt_read = 1'b1;
    repeat (5) step();
    bus.ifm_read = 1'b0; bus.wgt_read = 1'b0;
    n_done_before = done_cyc.size();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abt_busy", busy, 0);
    repeat (4) step();
    chk("abt_no_done", done_cyc.size(), n_done_before);
    pulse_start();
    chk("abt_restart_sc", bus.start_conv, 1);
    chk("abt_restart_ci", ci_idx, 0);
    chk("abt_restart_co", co_idx, 0);
    chk("abt_restart_ifm", bus.ifm_addr, 0);
    chk("abt_restart_wgt", bus.wgt_addr, 0);
    chk("abt_restart_ofm", bus.ofm_addr, 0);

    // ---------------- async reset mid-RUN -----------------------------------
    step();
    bus.ifm_read = 1'b1; bus.wgt_read = 1'b1;
    repeat (3) step();
    bus.ifm_read = 1'b0; bus.wgt_read = 1'b0;
    chk("ar_pre_ifm", bus.ifm_addr, 3);
    chk("ar_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_ifm", bus.ifm_addr, 0);
    chk("ar_wgt", bus.wgt_addr, 0);
    chk("ar_ofm", bus.ofm_addr, 0);
    chk("ar_ci_co", {ci_idx, co_idx}, 0);
    chk("ar_flags", {done, err, bus.start_conv, bus.ofm_we}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
